// File: rtl/change_pkg.sv
// Shared types for the change-record issue queue: default widths,
// FSM encoding and the packed record width helper.
package change_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int ELEM_W_DEF  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    function automatic int rec_w(input int cw, input int ew);
        return 2 * cw + ew;
    endfunction

endpackage

// File: rtl/change_fifo.sv
// Synchronous FIFO of packed change records; pointers carry one wrap
// bit so full and empty are told apart without a separate counter.
module change_fifo
    import change_pkg::*;
#(
    parameter int W     = 80,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign empty = (wr_q == rd_q);
    assign level = wr_q - rd_q;
    assign rdata = mem_q[rd_q[AW-1:0]];

    // flush wins over a same-edge push, which is simply dropped
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/change_issue_queue.sv
// Buffers change records and sequences them into the vector-update core
// over the EnableChange / EOC_Flag handshake, with a recovery watchdog.
module change_issue_queue
    import change_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [ELEM_W-1:0]  in_elem,
    input  logic               flush,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [ELEM_W-1:0]  NewElement,
    output logic               EnableChange,
    input  logic               EOC_Flag,
    output logic [LW-1:0]      level,
    output logic               drained,
    output logic [CNT_W-1:0]   issued_count,
    output logic               err_timeout
);

    localparam int RW = rec_w(COORD_W, ELEM_W);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [ELEM_W-1:0]  elem_q, elem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [WW-1:0]      wd_q, wd_d;

    logic               push;
    logic               pop;
    logic               fflush;
    logic               full;
    logic               empty;
    logic               timeout;
    logic [RW-1:0]      head;

    change_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (fflush),
        .wdata ({in_x, in_y, in_elem}),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign push         = in_valid && !full;
    assign in_ready     = !full;
    assign drained      = empty && (state_q == IDLE) && EOC_Flag;
    assign X            = x_q;
    assign Y            = y_q;
    assign NewElement   = elem_q;
    assign EnableChange = en_q;
    assign issued_count = cnt_q;
    assign err_timeout  = err_q;
    assign timeout      = (state_q != IDLE) && (wd_q == WD_MAX);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        x_d     = x_q;
        y_d     = y_q;
        elem_d  = elem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        fflush  = 1'b0;
        if (state_q != IDLE) wd_d = wd_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    fflush = 1'b1;
                end else if (!empty && EOC_Flag) begin
                    {x_d, y_d, elem_d} = head;
                    en_d    = 1'b1;
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // head is dropped whether the core took it or the watchdog fired
                if (timeout) begin
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    pop     = 1'b1;
                    state_d = IDLE;
                end else if (!EOC_Flag) begin
                    en_d    = 1'b0;
                    pop     = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (EOC_Flag) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            elem_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            elem_q  <= elem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_change_issue_queue.sv
// Scoreboard bench for change_issue_queue with a small core model.
module tb_change_issue_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        eoc = 1'b1;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [47:0] in_elem = '0;
    logic        in_ready;
    logic [15:0] X, Y;
    logic [47:0] NewElement;
    logic        EnableChange;
    logic [3:0]  level;
    logic        drained;
    logic [15:0] issued_count;
    logic        err_timeout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [79:0] exp_q [$];
    int          busy = 0;
    int          busy_len = 5;
    int          en_rises = 0;
    logic        en_prev = 1'b0;
    logic        stall = 1'b0;
    logic        hang = 1'b0;
    logic        deaf = 1'b0;
    logic        acc;
    int          r0;

    change_issue_queue #(
        .COORD_W (16),
        .ELEM_W  (48),
        .DEPTH   (8),
        .CNT_W   (16),
        .TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_elem      (in_elem),
        .flush        (flush),
        .X            (X),
        .Y            (Y),
        .NewElement   (NewElement),
        .EnableChange (EnableChange),
        .EOC_Flag     (eoc),
        .level        (level),
        .drained      (drained),
        .issued_count (issued_count),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // core model: accepts a request by dropping EOC, stays busy busy_len cycles
    always @(negedge clock) begin
        if (!reset) begin
            eoc     = 1'b1;
            busy    = 0;
            en_prev = 1'b0;
        end else begin
            if (EnableChange && !en_prev) en_rises++;
            en_prev = EnableChange;
            if (stall) begin
                eoc = 1'b0;
            end else if (busy != 0) begin
                if (!hang) busy--;
                if (busy == 0) eoc = 1'b1;
            end else if (!eoc) begin
                eoc = 1'b1;
            end else if (EnableChange && !deaf) begin
                if (exp_q.size() == 0) check("sb_unexpected", 80'd1, 80'd0);
                else check("sb_data", {X, Y, NewElement}, exp_q.pop_front());
                eoc  = 1'b0;
                busy = busy_len;
            end
        end
    end

    task automatic push_rec(input logic [15:0] x, input logic [15:0] y,
                            input logic [47:0] e, output logic ok);
        in_x     = x;
        in_y     = y;
        in_elem  = e;
        in_valid = 1'b1;
        ok       = in_ready;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (ok) exp_q.push_back({x, y, e});
    endtask

    task automatic wait_drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clock);
            #1;
            ok = drained && (exp_q.size() == 0);
        end
        check(tag, 80'(ok), 80'd1);
    endtask

    initial begin
        #3 reset = 1'b0;
        #10;
        check("rst_in_ready", 80'(in_ready), 80'd1);
        check("rst_en", 80'(EnableChange), 80'd0);
        check("rst_level", 80'(level), 80'd0);
        check("rst_cnt", 80'(issued_count), 80'd0);
        check("rst_err", 80'(err_timeout), 80'd0);
        check("rst_drained", 80'(drained), 80'd1);
        check("rst_data", {X, Y, NewElement}, 80'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // single record, one pulse, latency one edge
        push_rec(16'd3, 16'd7, 48'h0000_0012_3456, acc);
        check("lat_k", 80'(EnableChange), 80'd0);
        @(posedge clock);
        #1;
        check("lat_k1", 80'(EnableChange), 80'd1);
        wait_drain("single_drain");
        check("single_cnt", 80'(issued_count), 80'd1);
        check("single_pulses", 80'(en_rises), 80'd1);
        check("single_drained", 80'(drained), 80'd1);

        // fill to full with the core stalled
        stall = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 9; i++) begin
            push_rec(16'(i + 100), 16'($urandom), {16'hA5A5, 32'($urandom)}, acc);
            if (i == 7) begin
                check("full_ready", 80'(in_ready), 80'd0);
                check("full_level", 80'(level), 80'd8);
            end
            if (i == 8) check("full_held", 80'(acc), 80'd0);
        end
        check("full_level2", 80'(level), 80'd8);
        stall = 1'b0;
        wait_drain("full_drain");
        check("full_cnt", 80'(issued_count), 80'd9);
        check("full_pulses", 80'(en_rises), 80'd9);

        // push and pop on the same edge at level 3
        deaf = 1'b1;
        push_rec(16'h11, 16'h21, 48'h31, acc);
        push_rec(16'h12, 16'h22, 48'h32, acc);
        push_rec(16'h13, 16'h23, 48'h33, acc);
        @(posedge clock);
        #1;
        check("pp_level_pre", 80'(level), 80'd3);
        check("pp_en", 80'(EnableChange), 80'd1);
        deaf = 1'b0;
        push_rec(16'h14, 16'h24, 48'h34, acc);
        check("pp_level", 80'(level), 80'd3);
        wait_drain("pp_drain");
        check("pp_cnt", 80'(issued_count), 80'd13);

        // watchdog: core accepts and never returns
        hang = 1'b1;
        push_rec(16'hD1, 16'hD2, 48'hDEAD, acc);
        push_rec(16'hE1, 16'hE2, 48'hBEEF, acc);
        check("wd_en", 80'(EnableChange), 80'd1);
        repeat (15) @(posedge clock);
        #1;
        check("wd_err_early", 80'(err_timeout), 80'd0);
        @(posedge clock);
        #1;
        check("wd_err", 80'(err_timeout), 80'd1);
        check("wd_en_low", 80'(EnableChange), 80'd0);
        check("wd_level", 80'(level), 80'd1);
        check("wd_cnt_hold", 80'(issued_count), 80'd13);
        hang = 1'b0;
        wait_drain("wd_drain");
        check("wd_cnt", 80'(issued_count), 80'd14);
        check("wd_sticky", 80'(err_timeout), 80'd1);

        // flush in IDLE, including a same-edge push
        stall = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++)
            push_rec(16'(i + 200), 16'(i), 48'(i), acc);
        check("fl_level5", 80'(level), 80'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_x     = 16'hFFFF;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_level0", 80'(level), 80'd0);
        check("fl_en", 80'(EnableChange), 80'd0);
        exp_q.delete();
        r0    = en_rises;
        stall = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("fl_no_issue", 80'(en_rises), 80'(r0));
        check("fl_drained", 80'(drained), 80'd1);

        // flush while BUSY is ignored
        push_rec(16'hA1, 16'hA2, 48'hA3, acc);
        push_rec(16'hB1, 16'hB2, 48'hB3, acc);
        @(posedge clock);
        #1;
        check("flb_level_pre", 80'(level), 80'd1);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flb_level", 80'(level), 80'd1);
        wait_drain("flb_drain");
        check("flb_cnt", 80'(issued_count), 80'd16);

        // asynchronous reset during ISSUE
        deaf = 1'b1;
        push_rec(16'h55, 16'h66, 48'h77, acc);
        @(posedge clock);
        #1;
        check("ar_en_pre", 80'(EnableChange), 80'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_en", 80'(EnableChange), 80'd0);
        check("ar_level", 80'(level), 80'd0);
        check("ar_data", {X, Y, NewElement}, 80'd0);
        check("ar_cnt", 80'(issued_count), 80'd0);
        check("ar_err", 80'(err_timeout), 80'd0);
        exp_q.delete();
        #3 reset = 1'b1;
        deaf = 1'b0;
        @(posedge clock);
        #1;
        check("ar_drained", 80'(drained), 80'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/change_issue_queue.md
# change_issue_queue

Parametrised hardware issuer for change records (X, Y, NewElement). It sits between any record producer (host loader, DMA, or testbench driver) and the vector-update core. It buffers records in a FIFO and sequences them into the core one at a time using the core's EnableChange / EOC_Flag handshake. It adds configurable widths and depth, a completion counter, a drain indication, flush, and a watchdog that recovers from a core that never completes.

## Interface
Parameters:
- COORD_W, 16: width of X and Y.
- ELEM_W, 48: width of NewElement.
- DEPTH, 8: FIFO entries; must be a power of two, ≥2.
- CNT_W, 16: width of issued_count.
- TIMEOUT, 1024: maximum cycles from EnableChange rise to EOC_Flag return high; must be ≥4.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers a record.
- in_ready  out  1  FIFO can accept; equals !full.
- in_x, in_y  in  COORD_W  record coordinates.
- in_elem  in  ELEM_W  record payload.
- flush  in  1  discard all queued records; honoured only in IDLE.
- X, Y  out  COORD_W  coordinates presented to the core.
- NewElement  out  ELEM_W  payload presented to the core.
- EnableChange  out  1  request to the core.
- EOC_Flag  in  1  core end-of-change: high means the core is idle or done, low means it is busy.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- drained  out  1  FIFO empty, FSM in IDLE, and EOC_Flag high.
- issued_count  out  CNT_W  records the core has completed; wraps modulo 2^CNT_W.
- err_timeout  out  1  sticky watchdog error; cleared only by reset.

## Operation
- Push: a record is written when in_valid && in_ready on a rising edge.
- Pop: the head record is removed on the cycle it is accepted (see ISSUE) or abandoned by the watchdog. A push and a pop in the same edge leave level unchanged.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - Transition condition: level≠0 && EOC_Flag==1 && !flush.
  - Actions on the transition: register X, Y and NewElement from the head, set EnableChange=1, clear the watchdog counter, go to ISSUE.
- ISSUE: hold EnableChange and the data stable.
  - On EOC_Flag==0 (core accepted): EnableChange=0, pop the head, go to BUSY.
- BUSY:
  - On EOC_Flag==1: issued_count+1, go to IDLE.
  - X, Y and NewElement hold their last values until the next issue.
- Watchdog:
  - The counter increments every cycle in ISSUE or BUSY.
  - On reaching TIMEOUT-1: set err_timeout, drop EnableChange, pop the head if it has not been popped yet, and go to IDLE. issued_count is not incremented.
- flush:
  - In IDLE, clears the FIFO pointers on that edge. No issue starts that cycle, even if a push was accepted the same edge; that push is discarded.
  - Outside IDLE, flush is ignored.
- Arithmetic: FIFO pointers are $clog2(DEPTH) bits plus one wrap bit. full = (pointers equal, wrap bits differ); empty = (pointers equal, wrap bits equal).

## Timing
- Reset values: in_ready=1, X=0, Y=0, NewElement=0, EnableChange=0, level=0, issued_count=0, err_timeout=0, state=IDLE. drained=1 if EOC_Flag is high.
- Issue latency: a push accepted at edge k into an empty queue, with the FSM in IDLE and EOC_Flag high, raises EnableChange after edge k+1.
- Back-to-back: the next issue rises one cycle after the BUSY→IDLE edge, provided EOC_Flag is still high.
- All outputs are registered except in_ready and drained, which are combinational from registers and EOC_Flag.
- reset asserted mid-operation clears everything immediately, including EnableChange. Records in the FIFO are lost.

## Structure
- Shared package change_pkg holds COORD_W/ELEM_W defaults, the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2), and the packed record width COORD_W*2+ELEM_W.
- One sub-module, change_fifo: a synchronous FIFO over packed records, providing level, full and empty. The FSM, watchdog and counters stay in change_issue_queue.

## Test plan
- Single record: push X=3, Y=7, elem=48'h0000_0012_3456; core model drops EOC for 5 cycles -> EnableChange rises one edge after the push, one pulse only, issued_count=1, drained=1.
- Fill to full: DEPTH=8, push 9 records with the core stalled -> in_ready=0 after the 8th push and the 9th is held off. Release the core -> all 8 issued in order; issued_count=8.
- Simultaneous push and pop at level=3 -> level stays 3, ordering is preserved.
- Watchdog: TIMEOUT=16, core accepts (EOC low) but never returns high -> err_timeout=1 at cycle 16, head dropped, next record issued once EOC rises; issued_count excludes the lost record.
- flush in IDLE with level=5 -> level=0 next edge, no EnableChange. flush during BUSY -> ignored, level unchanged.
- reset asserted low during ISSUE -> EnableChange=0 and level=0 without waiting for a clock edge; after reset, X=Y=0 and issued_count=0.
